// File: rtl/gcd_pkg.sv
// Shared types and helpers for the sequential GCD engine.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam logic MODE_SUB = 1'b0;
    localparam logic MODE_BIN = 1'b1;

    // Width of the common power-of-two shift count; k can reach W-1.
    function automatic int k_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/gcd_step.sv
// One combinational GCD reduction step: termination test, then a subtractive
// or binary (Stein) step on the current operand pair.
module gcd_step
    import gcd_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         mode_i,
    output logic [W-1:0] a_o,
    output logic [W-1:0] b_o,
    output logic         k_inc_o,
    output logic         done_o,
    output logic [W-1:0] result_o
);

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        a_o      = a_i;
        b_o      = b_i;
        k_inc_o  = 1'b0;
        done_o   = 1'b0;
        result_o = a_i;

        if (a_i == b_i) begin
            done_o = 1'b1;
        end else if (a_i == '0) begin
            done_o   = 1'b1;
            result_o = b_i;
        end else if (b_i == '0) begin
            done_o = 1'b1;
        end else if (mode_i == MODE_SUB) begin
            if (a_i > b_i) a_o = a_i - b_i;
            else           b_o = b_i - a_i;
        end else begin
            unique case ({a_i[0], b_i[0]})
                2'b00: begin
                    a_o     = a_i >> 1;
                    b_o     = b_i >> 1;
                    k_inc_o = 1'b1;
                end
                2'b01:   a_o = a_i >> 1;
                2'b10:   b_o = b_i >> 1;
                default: begin
                    // Both odd: subtract smaller from larger so nothing underflows.
                    if (a_i > b_i) a_o = a_i - b_i;
                    else           b_o = b_i - a_i;
                end
            endcase
        end
    end

endmodule

// File: rtl/gcd_seq.sv
// Handshaked iterative GCD engine: accepts one operand pair, reduces it one
// step per clock, and holds the result plus its CALC cycle count until taken.
module gcd_seq
    import gcd_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = W + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    input  logic          in_mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_gcd,
    output logic [CW-1:0] out_cycles
);

    localparam int KW = k_width(W);

    state_t        state_q;
    logic [W-1:0]  a_q, b_q, gcd_q;
    logic          mode_q;
    logic [KW-1:0] k_q;
    logic [CW-1:0] cnt_q, cycles_q;
    logic          in_ready_q, out_valid_q;

    logic [W-1:0]  a_d, b_d, result_d;
    logic          k_inc_d, done_d;
    logic [CW-1:0] cnt_inc_d;

    gcd_step #(.W(W)) u_step (
        .a_i      (a_q),
        .b_i      (b_q),
        .mode_i   (mode_q),
        .a_o      (a_d),
        .b_o      (b_d),
        .k_inc_o  (k_inc_d),
        .done_o   (done_d),
        .result_o (result_d)
    );

    assign cnt_inc_d = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);

    // NOTE: non-blocking assignments so every register sees pre-edge values
    // regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            mode_q      <= MODE_SUB;
            k_q         <= '0;
            cnt_q       <= '0;
            gcd_q       <= '0;
            cycles_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= in_a;
                        b_q        <= in_b;
                        mode_q     <= in_mode;
                        k_q        <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    if (done_d) begin
                        // k stays zero in subtractive mode, so one shift serves both.
                        gcd_q       <= result_d << k_q;
                        cycles_q    <= cnt_inc_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        a_q   <= a_d;
                        b_q   <= b_d;
                        cnt_q <= cnt_inc_d;
                        if (k_inc_d) k_q <= k_q + KW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_gcd    = gcd_q;
    assign out_cycles = cycles_q;

endmodule

// File: tb/tb_gcd_seq.sv
// Directed and random bench for gcd_seq with a queue of expected results
// and an independent modulo-based GCD reference.
module tb_gcd_seq;

    localparam int W  = 8;
    localparam int CW = W + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_gcd;
    logic [CW-1:0] out_cycles;

    gcd_seq #(.W(W), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_mode    (in_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_gcd    (out_gcd),
        .out_cycles (out_cycles)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0]  gcd;
        logic [CW-1:0] cycles;
        bit            chk_cyc;
        int            acc;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        int x, y, t;
        x = int'(a);
        y = int'(b);
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return W'(x);
    endfunction

    // exp_cyc / lat < 0 means "do not check"; push = 0 means no result is expected.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                        input bit push, input int exp_cyc, input int lat);
        exp_t e;
        int   budget;
        budget   = 0;
        in_a     = a;
        in_b     = b;
        in_mode  = m;
        in_valid = 1'b1;
        while (!in_ready && budget < 1000) begin
            tick();
            budget++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        if (push) begin
            e.gcd     = ref_gcd(a, b);
            e.chk_cyc = (exp_cyc >= 0);
            e.cycles  = CW'(exp_cyc);
            e.acc     = cyc - 1;
            e.lat     = lat;
            sb.push_back(e);
        end
    endtask

    task automatic receive(input int hold);
        exp_t e;
        int   budget;
        budget    = 0;
        out_ready = 1'b0;
        while (!out_valid && budget < 2000) begin
            tick();
            budget++;
        end
        check("out_valid_wait", 32'(out_valid), 32'd1);
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        if (e.lat >= 0) check("latency", 32'(cyc - e.acc), 32'(e.lat));
        for (int i = 0; i < hold; i++) begin
            check("hold_gcd", 32'(out_gcd), 32'(e.gcd));
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        check("gcd", 32'(out_gcd), 32'(e.gcd));
        if (e.chk_cyc) check("cycles", 32'(out_cycles), 32'(e.cycles));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("in_ready_after", 32'(in_ready), 32'd1);
        check("out_valid_after", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            spurious;
        logic [W-1:0]  ra, rb;
        logic          rm;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_mode   = 1'b0;
        out_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_gcd", 32'(out_gcd), 32'd0);
        check("reset_out_cycles", 32'(out_cycles), 32'd0);

        send(8'd48, 8'd18, 1'b0, 1'b1, 5, 6);
        receive(0);
        send(8'd48, 8'd18, 1'b1, 1'b1, 7, 8);
        receive(0);

        for (int m = 0; m < 2; m++) begin
            send(8'd0,  8'd25, 1'(m), 1'b1, 1, 2);
            receive(0);
            send(8'd25, 8'd0,  1'(m), 1'b1, 1, 2);
            receive(0);
            send(8'd0,  8'd0,  1'(m), 1'b1, 1, 2);
            receive(0);
            send(8'd37, 8'd37, 1'(m), 1'b1, 1, 2);
            receive(0);
        end

        send(8'd255, 8'd1, 1'b0, 1'b1, 255, 256);
        receive(0);
        send(8'd255, 8'd1, 1'b1, 1'b1, -1, -1);
        receive(0);

        // Back-pressure with a new pair already waiting at the input.
        send(8'd12, 8'd8, 1'b0, 1'b1, 3, 4);
        in_a     = 8'd9;
        in_b     = 8'd6;
        in_mode  = 1'b1;
        in_valid = 1'b1;
        receive(10);
        send(8'd9, 8'd6, 1'b1, 1'b1, 4, 5);
        receive(0);

        // Abort a long subtractive run in its 20th CALC cycle.
        send(8'd255, 8'd1, 1'b0, 1'b0, -1, -1);
        repeat (19) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_out_gcd", 32'(out_gcd), 32'd0);
        check("abort_out_cycles", 32'(out_cycles), 32'd0);
        spurious = 0;
        repeat (300) begin
            tick();
            if (out_valid || !in_ready) spurious++;
        end
        check("abort_no_spurious", 32'(spurious), 32'd0);

        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            rm = 1'($urandom_range(0, 1));
            send(ra, rb, rm, 1'b1, -1, -1);
            receive(int'($urandom_range(0, 3)));
        end

        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gcd_seq.md
Name: gcd_seq

Overview:
- Iterative, handshaked GCD engine for unsigned W-bit operand pairs. Performs one reduction step per clock.
- Two run-time modes: subtractive (Euclid by subtraction) and binary (Stein).
- Reports the result plus the number of compute cycles used.
- Serves as the sequential, parametrised successor to the team's combinational GCD. It sits behind a valid/ready producer and in front of a valid/ready consumer.

Parameters:
- W, 8, operand and result width in bits (W >= 2).
- CW, W+1, cycle-counter width; the counter saturates at 2^CW-1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept a new pair.
- in_a  in  W  operand A, unsigned.
- in_b  in  W  operand B, unsigned.
- in_mode  in  1  0 = subtractive, 1 = binary; sampled at accept.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_gcd  out  W  gcd(A,B); gcd(0,0) = 0.
- out_cycles  out  CW  number of CALC cycles spent, including the terminating cycle.

Behaviour:
- Reset values (synchronous, only on a clk edge with rst=1):
  - state = IDLE, in_ready = 1, out_valid = 0, out_gcd = 0, out_cycles = 0.
  - Internal A, B, k and the counter are cleared.
- rst during CALC or DONE aborts the operation. No result is produced and the block is back in IDLE with in_ready = 1 on the following cycle.
- States: IDLE, CALC, DONE. in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
- IDLE:
  - Accept occurs when in_valid && in_ready.
  - On accept, latch A = in_a, B = in_b, mode = in_mode, k = 0, cnt = 0, and go to CALC.
  - No combinational path from in_valid to in_ready.
- CALC, one step per cycle; cnt increments by 1 each CALC cycle (saturating). Check termination first, in priority order:
  - A == B -> result = A.
  - A == 0 -> result = B.
  - B == 0 -> result = A.
  - On termination: out_gcd = result << k (k is always 0 in subtractive mode), out_cycles = cnt + 1 (saturating), go to DONE.
- CALC step when not terminating, subtractive mode:
  - If A > B, A = A - B; otherwise B = B - A.
- CALC step when not terminating, binary mode, in priority order:
  - Both even: A >>= 1, B >>= 1, k++.
  - Only A even: A >>= 1.
  - Only B even: B >>= 1.
  - Both odd: larger = larger - smaller.
- Width rules:
  - All datapath arithmetic is W-bit unsigned; subtraction never underflows because the larger operand is always chosen.
  - k needs ceil(log2(W+1)) bits.
  - The final shift cannot overflow, since the true GCD is no larger than max(in_a, in_b).
- DONE:
  - out_gcd and out_cycles are held stable while out_valid = 1 && !out_ready.
  - On out_ready, go to IDLE on the next cycle; the earliest new accept is the cycle after that.
- Latency: accept at cycle N -> out_valid at cycle N + 1 + out_cycles. Minimum is 2 (e.g. equal operands or a zero operand).
- Throughput: one operation in flight at a time; no pipelining.
- Simultaneous in_valid with out_valid is legal; the new pair waits until IDLE.
- Worst case: subtractive mode with (2^W-1, 1) takes 2^W-1 CALC cycles. CW = W+1 covers this without saturation.

Decomposition:
- Package gcd_pkg contains:
  - State enum {IDLE, CALC, DONE}.
  - Mode constants MODE_SUB = 1'b0, MODE_BIN = 1'b1.
  - A function that computes the k width from W.
- Sub-module gcd_step, purely combinational, one iteration.
  - Inputs: A, B, mode.
  - Outputs: next A, next B, k_inc, done, result.
- gcd_seq owns the FSM, registers, counter, handshake and final shift.

Test Plan:
- Subtractive: in (48,18,mode=0) -> out_gcd = 6, out_cycles = 5, out_valid 6 cycles after accept.
- Binary: in (48,18,mode=1) -> out_gcd = 6, out_cycles = 7 (steps (24,9)k=1, (12,9), (6,9), (3,9), (3,6), (3,3), terminate).
- Zeros, both modes:
  - (0,25) -> 25, out_cycles = 1.
  - (25,0) -> 25, out_cycles = 1.
  - (0,0) -> 0, out_cycles = 1.
  - (37,37) -> 37, out_cycles = 1.
- Worst case, W=8: (255,1,mode=0) -> 1, out_cycles = 255; (255,1,mode=1) -> 1.
- Back-pressure: hold out_ready = 0 for 10 cycles after (12,8).
  - out_gcd = 4 holds stable; in_ready stays 0 even with in_valid = 1.
  - Release out_ready -> in_ready = 1 on the next cycle.
- Reset mid-run: start (255,1,mode=0), assert rst at CALC cycle 20.
  - Next cycle: state IDLE, in_ready = 1, out_valid = 0, with no spurious result afterwards.
- Random: 1000 pairs in random modes with random out_ready; every result matches a golden model's gcd.
